// File: rtl/alu_pkg.sv
// Shared ALU control definitions for the MIPS datapath.
// The control decoder and the ALU both import this package so they agree on op encodings.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_XOR  = 4'b0011;
  localparam alu_op_t ALU_SLL  = 4'b0100;
  localparam alu_op_t ALU_SRL  = 4'b0101;
  localparam alu_op_t ALU_SUB  = 4'b0110;
  localparam alu_op_t ALU_SLT  = 4'b0111;
  localparam alu_op_t ALU_SRA  = 4'b1000;
  localparam alu_op_t ALU_SLTU = 4'b1001;
  localparam alu_op_t ALU_NOR  = 4'b1100;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU core: result, zero and signed-overflow from a, b and op.
// Reserved op codes produce a zero result with no overflow.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             ltSigned;
  logic             ltUnsigned;
  logic             addOvf;
  logic             subOvf;

  assign sum        = a + b;
  assign diff       = a - b;
  assign shamt      = b[SHW-1:0];
  // True signed compare, so SLT stays correct even when a-b overflows.
  assign ltSigned   = $signed(a) < $signed(b);
  assign ltUnsigned = a < b;
  assign addOvf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign subOvf     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = addOvf;
      end
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SUB: begin
        result   = diff;
        overflow = subOvf;
      end
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ltSigned};
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, ltUnsigned};
      ALU_NOR:  result = ~(a | b);
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_alu.sv
// Registered ALU: one-cycle latency wrapper around alu_comb.
// Outputs hold on idle cycles; out_valid tracks in_valid one cycle later.
module mips_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] combResult;
  logic             combZero;
  logic             combOverflow;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;
  logic             valid_q;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu_comb (
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (combResult),
    .zero     (combZero),
    .overflow (combOverflow)
  );

  always_comb begin
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    if (in_valid) begin
      result_d   = combResult;
      zero_d     = combZero;
      overflow_d = combOverflow;
    end
  end

  // Reset takes priority over any operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      valid_q    <= in_valid;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_mips_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    string       name;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic [31:0] opA;
  logic [31:0] opB;
  alu_op_t     aluOp;
  logic        inValid;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        outValid;

  exp_t expQ[$];
  int   total;
  int   bad;

  mips_alu #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .a         (opA),
    .b         (opB),
    .op        (aluOp),
    .in_valid  (inValid),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .out_valid (outValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input alu_op_t o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] expRes, input logic expZ, input logic expOv,
                               input string name);
    exp_t e;
    opA     = x;
    opB     = y;
    aluOp   = o;
    inValid = 1'b1;
    e.res   = expRes;
    e.z     = expZ;
    e.ov    = expOv;
    e.name  = name;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid output must correspond to exactly one queued expectation.
  always @(negedge clk) begin
    if (outValid === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got out_valid=1 expected no output (result 0x%08h)", result);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput({e.name, "_result"}, result, e.res);
        checkOutput({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.z});
        checkOutput({e.name, "_ovf"}, {31'b0, overflow}, {31'b0, e.ov});
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    rstN    = 1'b0;
    opA     = '0;
    opB     = '0;
    aluOp   = ALU_AND;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_zero", {31'b0, zero}, 32'h1);
    checkOutput("reset_ovf", {31'b0, overflow}, 32'h0);
    checkOutput("reset_valid", {31'b0, outValid}, 32'h0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(ALU_AND, 32'd6, 32'd2, 32'd2, 1'b0, 1'b0, "and_6_2");
    applyStimulus(ALU_OR,  32'd6, 32'd2, 32'd6, 1'b0, 1'b0, "or_6_2");
    applyStimulus(ALU_ADD, 32'd6, 32'd2, 32'd8, 1'b0, 1'b0, "add_6_2");
    applyStimulus(ALU_SUB, 32'd6, 32'd2, 32'd4, 1'b0, 1'b0, "sub_6_2");
    applyStimulus(ALU_XOR, 32'd6, 32'd2, 32'd4, 1'b0, 1'b0, "xor_6_2");
    applyStimulus(ALU_NOR, 32'd6, 32'd2, 32'hFFFF_FFF9, 1'b0, 1'b0, "nor_6_2");
    applyStimulus(ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, "sub_5_5");
    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0, "slt_m1_0");
    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    applyStimulus(ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");
    applyStimulus(ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1, 1'b1, "add_negovf");
    applyStimulus(ALU_SUB, 32'h0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_0_1");
    applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, "sltu_big");
    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, "slt_m1_1");
    applyStimulus(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1'b0, "slt_wrap");
    applyStimulus(ALU_SLL, 32'h8000_0010, 32'h24, 32'h0000_0100, 1'b0, 1'b0, "sll_4");
    applyStimulus(ALU_SRL, 32'h8000_0010, 32'h24, 32'h0800_0001, 1'b0, 1'b0, "srl_4");
    applyStimulus(ALU_SRA, 32'h8000_0010, 32'h24, 32'hF800_0001, 1'b0, 1'b0, "sra_4");

    opA     = 32'd0;
    opB     = 32'd0;
    aluOp   = ALU_AND;
    inValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hold_result", result, 32'hF800_0001);
    checkOutput("hold_zero", {31'b0, zero}, 32'h0);
    checkOutput("hold_valid", {31'b0, outValid}, 32'h0);

    applyStimulus(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0, "reserved");
    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, "pre_reset");

    rstN    = 1'b0;
    opA     = 32'd1;
    opB     = 32'd1;
    aluOp   = ALU_ADD;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_result", result, 32'h0);
    checkOutput("midreset_zero", {31'b0, zero}, 32'h1);
    checkOutput("midreset_ovf", {31'b0, overflow}, 32'h0);
    checkOutput("midreset_valid", {31'b0, outValid}, 32'h0);

    rstN = 1'b1;
    applyStimulus(ALU_SUB, 32'd6, 32'd2, 32'd4, 1'b0, 1'b0, "post_reset");
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d outstanding expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
# mips_alu

Registered 32-bit integer ALU for the single-cycle MIPS datapath, sitting between the register-file read ports and the write-back mux. Takes two operands and a 4-bit MIPS-style ALU control code. Produces a registered result plus zero and overflow flags one clock after the operands are presented.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; all requirements below are for 32.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `a`  in  32  operand A.
- `b`  in  32  operand B.
- `op`  in  4  ALU control code.
- `in_valid`  in  1  operands/op valid this cycle.
- `result`  out  32  registered result.
- `zero`  out  1  registered; 1 when the captured result is all zeros.
- `overflow`  out  1  registered signed overflow, valid for ADD/SUB only.
- `out_valid`  out  1  registered copy of `in_valid`.

## Operation
Op codes (all others are reserved and give result 0, overflow 0):
- 0000 AND: a & b.
- 0001 OR: a | b.
- 0010 ADD: a + b, modulo 2^32.
- 0011 XOR: a ^ b.
- 0100 SLL: a << b[4:0].
- 0101 SRL: a >> b[4:0], logical.
- 0110 SUB: a − b, modulo 2^32.
- 0111 SLT: 1 if signed(a) < signed(b), else 0. Use a true signed compare, not the sign of a−b.
- 1000 SRA: a >>> b[4:0], sign-filling.
- 1001 SLTU: 1 if unsigned(a) < unsigned(b), else 0.
- 1100 NOR: ~(a | b).

Rules:
- Shift amount is b[4:0]; b[31:5] is ignored for shifts.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
  - All other ops: 0.
- `zero` is computed from the combinational result before registering, so it always matches the registered `result`.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on `result`, `zero`, `overflow` and `out_valid` after edge N.
- When `in_valid` = 0:
  - `result`, `zero` and `overflow` hold their previous values.
  - `out_valid` goes to 0.
- No backpressure. A new operation may be accepted every cycle; back-to-back ops each produce a result one cycle later.
- Reset: when `rst_n` = 0 at a rising edge, the next state is `result` = 0, `zero` = 1, `overflow` = 0, `out_valid` = 0.
  - Reset wins over a simultaneous `in_valid` = 1; that operation is dropped.
  - Reset is applied mid-stream with no further effect.
- No internal state beyond the output registers.

## Structure
- Shared package `alu_pkg` holds:
  - the op-code localparams (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_SLL`, `ALU_SRL`, `ALU_SUB`, `ALU_SLT`, `ALU_SRA`, `ALU_SLTU`, `ALU_NOR`);
  - a 4-bit `alu_op_t` typedef.
- The control decoder that produces `op` imports the same package.
- One natural sub-module, `alu_comb`: purely combinational, computing result, zero and overflow from a, b and op.
- The top module adds only the output registers and reset.

## Test plan
- a=6, b=2, in_valid=1, ops applied on consecutive cycles:
  - AND → 2
  - OR → 6
  - ADD → 8
  - SUB → 4
  - each appears one cycle after its op; zero=0, overflow=0.
- Zero flag: a=5, b=5, SUB → result 0, zero=1. Then SLT with a=−1, b=0 → result 1, zero=0.
- Overflow and compares:
  - ADD 0x7FFFFFFF + 1 → result 0x80000000, overflow=1.
  - SUB 0x80000000 − 1 → result 0x7FFFFFFF, overflow=1.
  - SLTU with a=0xFFFFFFFF, b=1 → 0.
  - SLT with the same operands → 1.
- Shifts: a=0x80000010, b=0x24 (shamt 4):
  - SLL → 0x00000100
  - SRL → 0x08000001
  - SRA → 0xF8000001
- Hold and invalid op:
  - in_valid=0 → result unchanged, out_valid=0.
  - reserved op 1111 → result 0, zero=1.
- Reset: after non-zero results, drive rst_n=0 together with in_valid=1 and an ADD → next cycle result=0, zero=1, overflow=0, out_valid=0. Release reset; the next op is latched normally.
